// File: rtl/digit_display.sv
// Purpose: register-mapped 8-digit multiplexed seven-segment hex display driver.
// Latency: register writes reach rdata and the display outputs the cycle after the capture edge.
// Backpressure: none; every write is accepted and the scan never stalls.
module digit_display #(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  dig_en,
  output logic        DN_A,
  output logic        DN_B,
  output logic        DN_C,
  output logic        DN_D,
  output logic        DN_E,
  output logic        DN_F,
  output logic        DN_G,
  output logic        DN_DP
);

  // Terminal count of the per-digit dwell counter; 20 bits covers SCAN_DIV up to 2^20.
  localparam logic [19:0] CNT_MAX = 20'(SCAN_DIV - 1);

  logic [31:0] data_q, data_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  dp_q, dp_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;

  logic [3:0]  nibble;
  logic [6:0]  glyph;   // active-high segments, bit order {g,f,e,d,c,b,a}
  logic [7:0]  seg_n;   // active-low drives, bit order {dp,g,f,e,d,c,b,a}

  // Register writes and free-running scan; writes never disturb the scan.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    dp_d   = dp_q;
    cnt_d  = cnt_q + 20'd1;
    idx_d  = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
    if (we) begin
      case (addr)
        2'd0:    data_d = wdata;
        2'd1:    mask_d = wdata[7:0];
        2'd2:    dp_d   = wdata[7:0];
        default: ;  // STATUS is read-only
      endcase
    end
  end

  // State registers; reset wins over a coincident write.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      data_q <= '0;
      mask_q <= '0;
      dp_q   <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      dp_q   <= dp_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
    end
  end

  // Combinational register readback.
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = data_q;
      2'd1:    rdata = {24'b0, mask_q};
      2'd2:    rdata = {24'b0, dp_q};
      default: rdata = {29'b0, idx_q};
    endcase
  end

  // Hex glyph decode of the nibble belonging to the current digit.
  always_comb begin
    nibble = data_q[idx_q*4 +: 4];
    glyph  = 7'h00;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end

  // Digit enable and segment drives; a masked digit is fully dark.
  always_comb begin
    dig_en = 8'hFF;
    seg_n  = 8'hFF;
    if (mask_q[idx_q]) begin
      dig_en = ~(8'b1 << idx_q);
      seg_n  = {~dp_q[idx_q], ~glyph};
    end
  end

  assign DN_A  = seg_n[0];
  assign DN_B  = seg_n[1];
  assign DN_C  = seg_n[2];
  assign DN_D  = seg_n[3];
  assign DN_E  = seg_n[4];
  assign DN_F  = seg_n[5];
  assign DN_G  = seg_n[6];
  assign DN_DP = seg_n[7];

endmodule

// File: tb/tb_digit_display.sv
// Directed bench for digit_display: SCAN_DIV=4 main instance plus a SCAN_DIV=1 instance.
module tb_digit_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  dig_en;
  logic        dn_a, dn_b, dn_c, dn_d, dn_e, dn_f, dn_g, dn_dp;
  logic [7:0]  seg;

  logic [31:0] rdata1;
  logic [7:0]  dig_en1;
  logic        d1_a, d1_b, d1_c, d1_d, d1_e, d1_f, d1_g, d1_dp;

  int checks = 0;
  int errors = 0;
  int k = 0;  // non-reset clock edges since the last reset edge

  always #5 clk = ~clk;

  assign seg = {dn_dp, dn_g, dn_f, dn_e, dn_d, dn_c, dn_b, dn_a};

  digit_display #(.SCAN_DIV(4)) dut (
    .cpu_clk(clk), .cpu_rst(rst), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .dig_en(dig_en),
    .DN_A(dn_a), .DN_B(dn_b), .DN_C(dn_c), .DN_D(dn_d),
    .DN_E(dn_e), .DN_F(dn_f), .DN_G(dn_g), .DN_DP(dn_dp)
  );

  digit_display #(.SCAN_DIV(1)) dut1 (
    .cpu_clk(clk), .cpu_rst(rst), .we(1'b0), .addr(2'd3), .wdata(32'h0),
    .rdata(rdata1), .dig_en(dig_en1),
    .DN_A(d1_a), .DN_B(d1_b), .DN_C(d1_c), .DN_D(d1_d),
    .DN_E(d1_e), .DN_F(d1_f), .DN_G(d1_g), .DN_DP(d1_dp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) k = 0;
    else     k++;
    @(negedge clk);
  endtask

  function automatic int cur_idx();
    return (k / 4) % 8;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    logic [7:0] e_en;
    int         ix;

    rst = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
    @(negedge clk);
    step();
    step();

    // Reset state
    chk("rst_dig_en", dig_en, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    for (int a = 0; a < 4; a++) rdchk("rst_rdata", 2'(a), 32'h0);
    chk("rst_div1_idx", rdata1, 32'h0);
    rst = 1'b0;

    // Full scan of all eight digits
    wr(2'd0, 32'h7654_3210);
    wr(2'd1, 32'h0000_00FF);
    for (int j = 0; j < 34; j++) begin
      ix   = cur_idx();
      e_en = ~(8'b1 << ix);
      chk("scan_dig_en", dig_en, e_en);
      if (ix == 0) chk("scan_glyph0", seg, 8'hC0);
      if (ix == 1) chk("scan_glyph1", seg, 8'hF9);
      if (ix == 7) chk("scan_glyph7", seg, 8'hF8);
      step();
    end

    // Masking and decimal point
    wr(2'd1, 32'h0000_0005);
    wr(2'd2, 32'h0000_0004);
    for (int j = 0; j < 32; j++) begin
      ix   = cur_idx();
      e_en = (ix == 0) ? 8'hFE : (ix == 2) ? 8'hFB : 8'hFF;
      chk("mask_dig_en", dig_en, e_en);
      chk("mask_dp", dn_dp, (ix == 2) ? 32'h0 : 32'h1);
      if (ix == 0) chk("mask_glyph0", seg, 8'hC0);
      else if (ix == 2) chk("mask_glyph2_dp", seg, 8'h24);
      else chk("mask_blank", seg, 8'hFF);
      step();
    end

    // Write landing on the edge where idx advances 0 -> 1
    wr(2'd1, 32'h0000_00FF);
    wr(2'd2, 32'h0000_0000);
    while ((k + 1) % 32 != 4) step();
    wr(2'd0, 32'h0000_00A0);
    chk("wrap_dig_en", dig_en, 8'hFD);
    chk("wrap_glyphA", seg, 8'h88);

    // Readback, including ignored STATUS write
    wr(2'd3, 32'hFFFF_FFFF);
    rdchk("rb_status", 2'd3, 32'(cur_idx()));
    rdchk("rb_data", 2'd0, 32'h0000_00A0);
    wr(2'd1, 32'h1234_56AB);
    rdchk("rb_mask", 2'd1, 32'h0000_00AB);
    rdchk("rb_dp", 2'd2, 32'h0);

    // Reset mid-scan at idx 5 with a coincident write
    while (cur_idx() != 5) step();
    rdchk("pre_rst_idx", 2'd3, 32'd5);
    rst = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'hFFFF_FFFF;
    step();
    we = 1'b0; rst = 1'b0;
    chk("mid_rst_dig_en", dig_en, 8'hFF);
    chk("mid_rst_seg", seg, 8'hFF);
    rdchk("mid_rst_data", 2'd0, 32'h0);
    rdchk("mid_rst_mask", 2'd1, 32'h0);
    rdchk("mid_rst_idx", 2'd3, 32'h0);

    // Scan restarts from 0; SCAN_DIV=1 instance advances every cycle and wraps
    for (int j = 0; j < 10; j++) begin
      chk("div1_idx", rdata1, 32'(k % 8));
      rdchk("restart_idx", 2'd3, 32'(cur_idx()));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_display.md
DIGIT_DISPLAY -- requirements
Module: digit_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 20000, giving cpu_clk cycles each digit is lit (legal 1..2^20).
REQ-002 SHALL have port cpu_clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port cpu_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port we  input  1  bridge write strobe.
REQ-005 SHALL have port addr  input  2  register word select (byte address bits [3:2]).
REQ-006 SHALL have port wdata  input  32  write data.
REQ-007 SHALL have port rdata  output  32  read data.
REQ-008 SHALL have port dig_en  output  8  digit enables, active-low, bit i = digit i.
REQ-009 SHALL have ports DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP  output  1 each  segment drives, active-low.

Function
REQ-010 SHALL hold registers: DATA (addr 0, 32 bits, nibble i = digit i), MASK (addr 1, bits [7:0] digit enable), DP (addr 2, bits [7:0] decimal point); addr 3 = STATUS, read-only.
REQ-011 SHALL capture wdata into the addressed register on the rising edge where we=1; only low 8 bits for MASK/DP; writes to addr 3 ignored.
REQ-012 SHALL drive rdata combinationally: DATA; {24'b0,MASK}; {24'b0,DP}; {29'b0,idx} for addr 0/1/2/3.
REQ-013 SHALL keep a scan counter cnt counting 0..SCAN_DIV-1; at cnt=SCAN_DIV-1 cnt wraps to 0 and digit index idx (3 bits) increments, 7 wrapping to 0.
REQ-014 SHALL with SCAN_DIV=1 advance idx every cycle.
REQ-015 SHALL drive dig_en = ~(8'b1<<idx) when MASK[idx]=1, else 8'hFF.
REQ-016 SHALL decode nibble DATA[4*idx+3:4*idx] to standard hex glyphs, active-low: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-017 SHALL drive DN_DP = ~DP[idx] when MASK[idx]=1.
REQ-018 SHALL drive all eight segment outputs to 1 when MASK[idx]=0.
REQ-019 SHALL compute dig_en and segment outputs combinationally from registered DATA/MASK/DP/idx, so a write is visible on outputs the cycle after its capture edge.
REQ-020 SHALL, on a write coinciding with an idx advance, apply both: the next cycle shows the new register value on the new digit.
REQ-021 SHALL not stall or reset the scan on any register write.

Reset
REQ-022 SHALL, on cpu_clk edge with cpu_rst=1, clear cnt, idx, DATA, MASK, DP to 0; outputs then dig_en=8'hFF, all DN_*=1, rdata=0 for every addr.
REQ-023 SHALL give cpu_rst priority over a simultaneous we=1 (write discarded).
REQ-024 SHALL, on reset asserted mid-scan, restart at idx=0, cnt=0 the cycle after reset deasserts.

Verification (SCAN_DIV=4 unless stated)
REQ-025 SHALL cover reset: hold cpu_rst 2 cycles -> dig_en=8'hFF, DN_A..DN_DP=1, rdata addr 3 = 0.
REQ-026 SHALL cover scan: write DATA=32'h76543210, MASK=8'hFF -> dig_en steps FE,FD,FB,...,7F,FE, each held exactly 4 cycles; digit 0 shows "0" (DN_G=1, others 0), digit 1 shows "1" (only DN_B,DN_C=0).
REQ-027 SHALL cover masking/dp: MASK=8'h05, DP=8'h04 -> dig_en FE for idx0, FB for idx2, FF elsewhere; DN_DP=0 only while idx=2; all segments 1 on idx 1,3..7.
REQ-028 SHALL cover write on wrap: write DATA=32'h000000A0 on the edge where idx 0->1 -> next cycle digit 1 shows "A" (DN_D=1, others segment 0).
REQ-029 SHALL cover readback: write addr 3 = 32'hFFFFFFFF -> rdata addr 3 still equals current idx; rdata addr 1 after MASK write 32'h1234_56AB = 32'h000000AB.
REQ-030 SHALL cover reset mid-scan and SCAN_DIV=1: reset with idx=5 with we=1 -> write lost, idx=0; SCAN_DIV=1 -> idx increments every cycle, 7 wraps to 0.
